// File: rtl/game_pkg.sv
// +--------------------------------------------------------------------+
// | game_pkg : shared game-state types and screen geometry constants   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package game_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        WIPE = 2'd2,
        DONE = 2'd3
    } transition_state_t;

endpackage

`default_nettype wire

// File: rtl/start_transition_seq_if.sv
// +--------------------------------------------------------------------+
// | start_transition_seq_if : controller <-> transition sequencer bus  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface start_transition_seq_if;

    logic       FrameTick;
    logic       StartTransition;
    logic       StartTransitionDone;
    logic       TransitionActive;
    logic [9:0] WipeX;
    logic       BlinkOn;

    modport master (
        output FrameTick,
        output StartTransition,
        input  StartTransitionDone,
        input  TransitionActive,
        input  WipeX,
        input  BlinkOn
    );

    modport slave (
        input  FrameTick,
        input  StartTransition,
        output StartTransitionDone,
        output TransitionActive,
        output WipeX,
        output BlinkOn
    );

endinterface

`default_nettype wire

// File: rtl/frame_tick_counter.sv
// +--------------------------------------------------------------------+
// | frame_tick_counter : wrap-at-terminal tick counter with sync clear |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module frame_tick_counter #(
    parameter int TERMINAL = 8
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_clear,
    input  wire logic i_tick,
    output logic      o_at_terminal
);

    localparam int               WIDTH = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;
    localparam logic [WIDTH-1:0] LAST  = WIDTH'(TERMINAL - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_tick) begin
            count_d = (count_q == LAST) ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_at_terminal = (count_q == LAST);

endmodule

`default_nettype wire

// File: rtl/start_transition_seq.sv
// +--------------------------------------------------------------------+
// | start_transition_seq : title-to-game HOLD/WIPE transition responder|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module start_transition_seq #(
    parameter int SCREEN_W     = game_pkg::SCREEN_W,
    parameter int WIPE_STEP    = 16,
    parameter int HOLD_FRAMES  = 30,
    parameter int BLINK_FRAMES = 8
) (
    input  wire logic             Clk,
    input  wire logic             Reset_n,
    start_transition_seq_if.slave bus
);

    import game_pkg::*;

    localparam logic [9:0]  WIPE_END = 10'(SCREEN_W);
    localparam logic [10:0] STEP_11  = 11'(WIPE_STEP);

    transition_state_t state_q, state_d;
    logic [9:0]        wipe_x_q, wipe_x_d;
    logic              blink_q, blink_d;
    logic [10:0]       wipe_sum;
    logic [9:0]        wipe_next;
    logic              in_hold;
    logic              hold_tick;
    logic              cnt_clear;
    logic              frame_last;
    logic              blink_last;

    assign in_hold   = (state_q == HOLD);
    assign hold_tick = in_hold && bus.FrameTick;
    // Counters only run in HOLD; an abort clears them on the same edge.
    assign cnt_clear = !in_hold || !bus.StartTransition;

    frame_tick_counter #(.TERMINAL(HOLD_FRAMES)) u_frame_cnt (
        .clk           (Clk),
        .rst_n         (Reset_n),
        .i_clear       (cnt_clear),
        .i_tick        (hold_tick),
        .o_at_terminal (frame_last)
    );

    frame_tick_counter #(.TERMINAL(BLINK_FRAMES)) u_blink_cnt (
        .clk           (Clk),
        .rst_n         (Reset_n),
        .i_clear       (cnt_clear),
        .i_tick        (hold_tick),
        .o_at_terminal (blink_last)
    );

    always_comb begin
        wipe_sum  = {1'b0, wipe_x_q} + STEP_11;
        wipe_next = (wipe_sum >= {1'b0, WIPE_END}) ? WIPE_END : wipe_sum[9:0];
        state_d   = state_q;
        wipe_x_d  = wipe_x_q;
        blink_d   = blink_q;
        case (state_q)
            IDLE: begin
                wipe_x_d = '0;
                blink_d  = 1'b1;
                if (bus.StartTransition) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!bus.StartTransition) begin
                    state_d  = IDLE;
                    wipe_x_d = '0;
                    blink_d  = 1'b1;
                end else if (bus.FrameTick) begin
                    if (frame_last) begin
                        state_d = WIPE;
                        blink_d = 1'b1;
                    end else if (blink_last) begin
                        blink_d = !blink_q;
                    end
                end
            end
            WIPE: begin
                blink_d = 1'b1;
                if (!bus.StartTransition) begin
                    state_d  = IDLE;
                    wipe_x_d = '0;
                end else if (bus.FrameTick) begin
                    wipe_x_d = wipe_next;
                    if (wipe_next == WIPE_END) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                wipe_x_d = WIPE_END;
                blink_d  = 1'b1;
                if (!bus.StartTransition) begin
                    state_d  = IDLE;
                    wipe_x_d = '0;
                end
            end
            default: begin
                state_d  = IDLE;
                wipe_x_d = '0;
                blink_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            wipe_x_q <= '0;
            blink_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            wipe_x_q <= wipe_x_d;
            blink_q  <= blink_d;
        end
    end

    assign bus.StartTransitionDone = (state_q == DONE);
    assign bus.TransitionActive    = (state_q == HOLD) || (state_q == WIPE);
    assign bus.WipeX               = wipe_x_q;
    assign bus.BlinkOn             = blink_q;

endmodule

`default_nettype wire

// File: tb/tb_start_transition_seq.sv
// +--------------------------------------------------------------------+
// | tb_start_transition_seq : vector table, directed and random checks |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_start_transition_seq;

    logic Clk = 1'b0;
    logic Reset_n;
    always #5 Clk = ~Clk;

    start_transition_seq_if bus0();
    start_transition_seq_if bus1();

    start_transition_seq dut0 (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus0.slave)
    );

    start_transition_seq #(
        .SCREEN_W     (100),
        .WIPE_STEP    (30),
        .HOLD_FRAMES  (2),
        .BLINK_FRAMES (1)
    ) dut1 (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus1.slave)
    );

    // Reference model: phase 0 idle, 1 hold, 2 wipe, 3 done; counts ticks per phase.
    int p_w[2] = '{640, 100};
    int p_s[2] = '{16, 30};
    int p_h[2] = '{30, 2};
    int p_b[2] = '{8, 1};
    int ph[2];
    int hk[2];
    int wn[2];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic st;
        logic tk;
        logic done;
        logic act;
        int   wipe;
        logic blink;
    } vec_t;

    vec_t vt[10];

    function automatic int wipe_of(int d, int n);
        int v;
        v = n * p_s[d];
        return (v > p_w[d]) ? p_w[d] : v;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ph[d] = 0;
            hk[d] = 0;
            wn[d] = 0;
        end
    endtask

    task automatic model_step(input logic st, input logic tk);
        for (int d = 0; d < 2; d++) begin
            case (ph[d])
                0: if (st) begin ph[d] = 1; hk[d] = 0; wn[d] = 0; end
                1: if (!st) ph[d] = 0;
                   else if (tk) begin
                       hk[d]++;
                       if (hk[d] == p_h[d]) begin ph[d] = 2; wn[d] = 0; end
                   end
                2: if (!st) ph[d] = 0;
                   else if (tk) begin
                       wn[d]++;
                       if (wipe_of(d, wn[d]) == p_w[d]) ph[d] = 3;
                   end
                default: if (!st) ph[d] = 0;
            endcase
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        for (int d = 0; d < 2; d++) begin
            int a_done, a_act, a_wipe, a_blink;
            int e_wipe, e_blink;
            if (d == 0) begin
                a_done = bus0.StartTransitionDone; a_act = bus0.TransitionActive;
                a_wipe = bus0.WipeX;               a_blink = bus0.BlinkOn;
            end else begin
                a_done = bus1.StartTransitionDone; a_act = bus1.TransitionActive;
                a_wipe = bus1.WipeX;               a_blink = bus1.BlinkOn;
            end
            e_wipe  = (ph[d] >= 2) ? wipe_of(d, wn[d]) : 0;
            e_blink = (ph[d] == 1) ? int'(((hk[d] / p_b[d]) % 2) == 0) : 1;
            chk($sformatf("d%0d.done", d),   a_done,  int'(ph[d] == 3));
            chk($sformatf("d%0d.active", d), a_act,   int'(ph[d] == 1 || ph[d] == 2));
            chk($sformatf("d%0d.wipe", d),   a_wipe,  e_wipe);
            chk($sformatf("d%0d.blink", d),  a_blink, e_blink);
        end
    endtask

    task automatic cyc(input logic st, input logic tk);
        bus0.StartTransition = st;
        bus1.StartTransition = st;
        bus0.FrameTick       = tk;
        bus1.FrameTick       = tk;
        @(posedge Clk);
        model_step(st, tk);
        #1;
        check_model();
    endtask

    initial begin
        int sat_exp[4];
        sat_exp = '{30, 60, 90, 100};

        Reset_n = 1'b0;
        bus0.StartTransition = 1'b0; bus1.StartTransition = 1'b0;
        bus0.FrameTick       = 1'b0; bus1.FrameTick       = 1'b0;
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        chk("rst.done",   bus0.StartTransitionDone, 0);
        chk("rst.active", bus0.TransitionActive,    0);
        chk("rst.wipe",   bus0.WipeX,               0);
        chk("rst.blink",  bus0.BlinkOn,             1);
        #4 Reset_n = 1'b1;

        // Idle ignores ticks, request, abort in HOLD, re-request.
        for (int i = 0; i < 5; i++) vt[i] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1};
        vt[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b1};
        vt[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b1};
        vt[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1};
        vt[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b1};
        vt[9] = '{1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            cyc(vt[i].st, vt[i].tk);
            chk($sformatf("vec%0d.done", i),   bus0.StartTransitionDone, vt[i].done);
            chk($sformatf("vec%0d.active", i), bus0.TransitionActive,    vt[i].act);
            chk($sformatf("vec%0d.wipe", i),   bus0.WipeX,               vt[i].wipe);
            chk($sformatf("vec%0d.blink", i),  bus0.BlinkOn,             vt[i].blink);
        end
        cyc(1'b0, 1'b0);

        // Full default sequence, one tick every 20 cycles.
        cyc(1'b1, 1'b0);
        chk("full.active_after_req", bus0.TransitionActive, 1);
        for (int t = 1; t <= 70; t++) begin
            cyc(1'b1, 1'b1);
            if (t == 8)  chk("full.blink_t8",  bus0.BlinkOn, 0);
            if (t == 16) chk("full.blink_t16", bus0.BlinkOn, 1);
            if (t == 24) chk("full.blink_t24", bus0.BlinkOn, 0);
            if (t == 31) chk("full.wipe_t31",  bus0.WipeX, 16);
            if (t == 50) chk("full.wipe_t50",  bus0.WipeX, 320);
            if (t == 69) chk("full.done_t69",  bus0.StartTransitionDone, 0);
            if (t == 70) begin
                chk("full.done_t70", bus0.StartTransitionDone, 1);
                chk("full.wipe_t70", bus0.WipeX, 640);
            end
            if (t < 70) repeat (19) cyc(1'b1, 1'b0);
        end
        repeat (10) cyc(1'b1, 1'b0);
        chk("hs.done_held", bus0.StartTransitionDone, 1);
        cyc(1'b0, 1'b0);
        chk("hs.done_drop", bus0.StartTransitionDone, 0);
        chk("hs.wipe_drop", bus0.WipeX, 0);

        // Saturation on the narrow instance.
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1);
            chk($sformatf("sat.wipe%0d", i), bus1.WipeX, sat_exp[i]);
            chk($sformatf("sat.done%0d", i), bus1.StartTransitionDone, int'(i == 3));
        end
        cyc(1'b1, 1'b1);
        chk("sat.wipe_hold", bus1.WipeX, 100);
        cyc(1'b0, 1'b0);

        // Abort in WIPE with a coincident tick.
        cyc(1'b1, 1'b0);
        for (int t = 1; t <= 45; t++) begin
            cyc(1'b1, 1'b1);
            cyc(1'b1, 1'b0);
        end
        chk("abort.wipe_before", bus0.WipeX, 240);
        cyc(1'b0, 1'b1);
        chk("abort.wipe",   bus0.WipeX, 0);
        chk("abort.active", bus0.TransitionActive, 0);
        chk("abort.done",   bus0.StartTransitionDone, 0);
        repeat (3) cyc(1'b0, 1'b0);

        // Asynchronous reset between edges mid-WIPE.
        cyc(1'b1, 1'b0);
        for (int t = 1; t <= 38; t++) begin
            cyc(1'b1, 1'b1);
            cyc(1'b1, 1'b0);
        end
        chk("arst.wipe_before", bus0.WipeX, 128);
        #2 Reset_n = 1'b0;
        #1;
        chk("arst.done",   bus0.StartTransitionDone, 0);
        chk("arst.active", bus0.TransitionActive,    0);
        chk("arst.wipe",   bus0.WipeX,               0);
        chk("arst.blink",  bus0.BlinkOn,             1);
        model_reset();
        check_model();
        #1 Reset_n = 1'b1;
        cyc(1'b1, 1'b0);
        chk("arst.rereq_active", bus0.TransitionActive, 1);
        repeat (5) cyc(1'b1, 1'b1);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            cyc(logic'($urandom_range(0, 63) != 0), logic'($urandom_range(0, 2) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/start_transition_seq.md
Name: start_transition_seq

Overview:
- Responder to the game-state controller's start-transition handshake. The controller raises StartTransition; this block runs the title-to-game transition and returns StartTransitionDone.
- Transition has two phases:
  - HOLD: blink the title prompt for HOLD_FRAMES frames.
  - WIPE: sweep a wipe edge across the screen, one step per frame.
- Sits between the state controller and the color mapper; the mapper consumes WipeX and BlinkOn.

Parameters:
- SCREEN_W, 640: screen width in pixels; wipe terminal value.
- WIPE_STEP, 16: pixels the wipe edge advances per frame tick.
- HOLD_FRAMES, 30: frame ticks spent in HOLD.
- BLINK_FRAMES, 8: frame ticks per BlinkOn half-period during HOLD.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- FrameTick  in  1  one-Clk-cycle pulse per video frame, synchronous to Clk.
- StartTransition  in  1  level request from the state controller.
- StartTransitionDone  out  1  level; high while in DONE.
- TransitionActive  out  1  high in HOLD or WIPE.
- WipeX  out  10  current wipe edge column, 0..SCREEN_W.
- BlinkOn  out  1  title prompt visible.

Behaviour:
- Reset values (Reset_n low, asynchronous):
  - state = IDLE; StartTransitionDone = 0; TransitionActive = 0; WipeX = 0; BlinkOn = 1.
  - Internal frame_cnt = 0; blink_cnt = 0.
- All outputs are registered or are decodes of registered state. No combinational path from any input to any output.
- States: IDLE, HOLD, WIPE, DONE.
- IDLE:
  - StartTransition high at an edge -> HOLD at that edge; frame_cnt and blink_cnt clear, BlinkOn = 1, WipeX = 0.
  - FrameTick is ignored.
- HOLD:
  - Each FrameTick increments frame_cnt.
  - On the tick where frame_cnt reaches HOLD_FRAMES-1 -> WIPE; frame_cnt clears.
  - blink_cnt counts ticks. When it reaches BLINK_FRAMES-1: BlinkOn toggles and blink_cnt clears.
- WIPE:
  - BlinkOn forced 1.
  - Each FrameTick: WipeX <= min(WipeX + WIPE_STEP, SCREEN_W). Compute the sum at 11 bits, then saturate; no wrap.
  - When the updated WipeX equals SCREEN_W -> DONE on the same edge.
- DONE:
  - StartTransitionDone = 1; WipeX holds SCREEN_W.
  - StartTransition low -> IDLE; WipeX and all counters clear. This completes a 4-phase handshake.
- Latency, defaults: StartTransitionDone rises in the cycle after the 70th FrameTick counted from HOLD entry (30 HOLD + 40 WIPE ticks).
- Abort: StartTransition low in HOLD or WIPE -> IDLE at that edge with the IDLE reset values. Abort wins over a simultaneous FrameTick.
- FrameTick coincident with the HOLD->WIPE edge is consumed by HOLD. WipeX starts advancing on the next tick.
- StartTransition high in the same cycle DONE->IDLE would occur is not possible: DONE leaves only on low. Re-request after IDLE starts a fresh sequence.
- Parameter constraints: WIPE_STEP non-zero; SCREEN_W < 1024; HOLD_FRAMES >= 1; BLINK_FRAMES >= 1.
- Asynchronous reset mid-sequence: immediate return to reset values; no Done glitch.

Decomposition:
- Shared package game_pkg:
  - transition_state_t enum (IDLE, HOLD, WIPE, DONE), logic [1:0].
  - Screen constants SCREEN_W and SCREEN_H, shared with the color mapper and the state controller.
- Natural sub-module: frame_tick_counter. A parameterised counter that counts on FrameTick, has a synchronous clear and a terminal-count flag. Instantiated twice, for frame_cnt and blink_cnt.

Test Plan:
- Reset: hold Reset_n low, then release -> Done=0, Active=0, WipeX=0, BlinkOn=1. Pulse FrameTick x5 with StartTransition low -> outputs unchanged.
- Full sequence (defaults): raise StartTransition, FrameTick every 20 cycles.
  - Active=1 the cycle after the request.
  - BlinkOn toggles after ticks 8, 16, 24.
  - WipeX=16 after tick 31 and 320 after tick 50.
  - Done=1 one cycle after tick 70, with WipeX=640.
- Handshake release: in DONE, hold StartTransition 10 more cycles -> Done stays 1. Drop it -> next cycle Done=0, WipeX=0, state IDLE.
- Abort: drop StartTransition after tick 45 (WIPE, WipeX=240), in the same cycle as a FrameTick -> next cycle WipeX=0, Active=0; Done never asserts.
- Saturation: SCREEN_W=100, WIPE_STEP=30 -> WipeX goes 30, 60, 90, 100. Done follows the 4th WIPE tick; WipeX never exceeds 100.
- Async reset mid-WIPE: assert Reset_n low between clock edges at WipeX=128 -> outputs return to reset values before the next edge. Re-request restarts from HOLD.
